cu_sdf_stage_seq: RTL and testbench
===================================

Name: cu_sdf_stage_seq

Overview:
Frame sequencer for one radix-2^2 SDF stage built from a 16-lane shift-register, 32-to-16 mux, BF2I and twiddle-multiplier datapath.
- Counts the 16-sample blocks of each frame.
- Drives mux select, butterfly enable, multiplier enable and twiddle select, aligned to the datapath pipeline.
- Emits the next stage's alert pulse and a frame-done pulse.
- Sits between the upstream stage's alert output and the next stage's alert input.

Parameters:
BLK_PER_FRAME, 32, blocks (16 lanes each) per frame; power of 2, >= 2*HALF_SPAN
HALF_SPAN, 8, blocks per butterfly half (delay-line depth in blocks); power of 2
OUT_LAT, 2, cycles from first second-half block at the input to first valid stage output; >= 1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
alert_in  input  1  one-cycle pulse; block 0 of a frame is at the datapath input on the following cycle
mux_sel  output  1  0 = pass add path, 1 = pass stored sub path
bf_en  output  1  butterfly enable
mul_en  output  1  twiddle multiplier enable
mul_val_sel  output  2  twiddle constant select
alert_out  output  1  one-cycle alert for the next stage
frame_done  output  1  one-cycle pulse when a frame has fully drained
busy  output  1  a frame is in flight or draining
err_resync  output  1  sticky; exists only with CU_SDF_RESYNC_EN

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset:
  - All outputs and internal pipeline flags go to 0 on the edge where rst=1.
  - State becomes IDLE. Pending alert_out and frame_done pulses are cancelled.
  - alert_in is ignored while rst=1.
- All outputs are registered.
- Timing reference: alert_in sampled at cycle T0. Block k (k = 0..BLK_PER_FRAME-1) is at the input during T0+1+k.
- Block counter cnt, width $clog2(BLK_PER_FRAME), equals k during block k.
- States: IDLE, RUN, DRAIN.
  - IDLE: on alert_in go to RUN with cnt=0.
  - RUN: cnt increments each cycle. After block BLK_PER_FRAME-1 go to DRAIN for OUT_LAT cycles, then IDLE.
- Alert acceptance:
  - alert_in is accepted in IDLE, in DRAIN, and in RUN when cnt = BLK_PER_FRAME-1 (back-to-back frame, no gap).
  - An accepted alert_in starts a new frame; cnt wraps to 0 with no bubble.
- Outputs for block k, valid during T0+1+k:
  - mux_sel = bf_en = bit log2(HALF_SPAN) of k, i.e. (k / HALF_SPAN) mod 2.
- mul_en = bf_en delayed 1 cycle.
- mul_val_sel = (k / HALF_SPAN) mod 4, delayed 1 cycle; it updates only when a block is valid and otherwise holds.
- Outside valid blocks (IDLE, DRAIN, post-frame): mux_sel and bf_en are 0.
- alert_out: pulse at T0 + HALF_SPAN + OUT_LAT, once per frame.
- frame_done: pulse OUT_LAT cycles after the cycle holding block BLK_PER_FRAME-1.
  - Implemented as a delay line of last-block flags, so overlapping frames each produce their own pulse.
- busy: 1 from T0+1 until the cycle of that frame's frame_done inclusive; stays 1 across back-to-back frames.
- A mid-frame alert_in (RUN, cnt != BLK_PER_FRAME-1) is handled per the optional feature below.

Optional Feature:
CU_SDF_RESYNC_EN
- Defined:
  - A mid-frame alert_in restarts the frame: cnt=0 on the next cycle and output sequencing restarts from block 0.
  - Pending alert_out and frame_done pulses of the aborted frame are cancelled.
  - err_resync is set to 1 and cleared only by rst.
- Undefined: a mid-frame alert_in is ignored and the current frame continues unchanged. The err_resync port does not exist.

Test Plan:
1. Reset: rst=1 for 3 cycles with alert_in toggling -> all outputs 0, busy=0. After release with no alert, outputs stay 0.
2. Single frame (defaults): alert_in at T0.
   - mux_sel/bf_en: 0 at T0+1..8, 1 at T0+9..16, 0 at T0+17..24, 1 at T0+25..32.
   - mul_en = bf_en shifted +1 cycle.
   - mul_val_sel 0,1,2,3 in 8-cycle runs starting T0+2.
   - alert_out at T0+10, frame_done at T0+34, busy 1 over T0+1..34 then 0.
3. Back-to-back: second alert_in at T0+32.
   - Block 0 of frame 2 at T0+33 with mux_sel pattern restarting; busy never drops.
   - alert_out at T0+10 and T0+42; frame_done at T0+34 and T0+66.
4. Mid-frame alert at T0+12:
   - With macro: pattern restarts at T0+13, alert_out at T0+22 only, err_resync=1 from T0+13.
   - Without macro: identical to scenario 2.
5. Reset mid-frame: rst=1 at T0+20 -> T0+21 all outputs 0, no alert_out or frame_done afterwards. A fresh alert_in then gives the scenario-2 timing.
6. Alert during DRAIN at T0+33: accepted; block 0 at T0+34, frame_done of frame 1 still at T0+34.

Source files
------------

// File: rtl/cu_sdf_stage_seq.sv
// Frame sequencer for one radix-2^2 SDF stage: block counter, datapath enables, alert/done pulses.
// Optional mid-frame resynchronisation (and the err_resync port) is enabled by defining CU_SDF_RESYNC_EN.
module cu_sdf_stage_seq #(
  parameter int BLK_PER_FRAME = 32,
  parameter int HALF_SPAN     = 8,
  parameter int OUT_LAT       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert_in,
  output logic       mux_sel,
  output logic       bf_en,
  output logic       mul_en,
  output logic [1:0] mul_val_sel,
  output logic       alert_out,
  output logic       frame_done,
  output logic       busy
`ifdef CU_SDF_RESYNC_EN
  ,
  output logic       err_resync
`endif
);

  // state | meaning
  // IDLE  | no frame in flight, waiting for alert_in
  // RUN   | a block of the frame is at the datapath input; cnt is its index
  // DRAIN | last block passed, pipeline emptying for OUT_LAT cycles
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int CW     = $clog2(BLK_PER_FRAME);
  localparam int LOG_HS = $clog2(HALF_SPAN);
  localparam int DW     = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
  localparam logic [CW-1:0] LAST    = CW'(BLK_PER_FRAME - 1);
  localparam logic [CW-1:0] HS_LAST = CW'(HALF_SPAN - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(OUT_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [OUT_LAT:0] al_pipe_q, al_pipe_d;
  logic [OUT_LAT:0] fd_pipe_q, fd_pipe_d;
  logic       mux_sel_q, mul_en_q, busy_q, err_q;
  logic [1:0] mvs_q, qtr;
  logic       start, resync, run_d;

  always_comb begin
    resync = 1'b0;
`ifdef CU_SDF_RESYNC_EN
    resync = alert_in && (state_q == RUN) && (cnt_q != LAST);
`endif
    start   = (alert_in && ((state_q != RUN) || (cnt_q == LAST))) || resync;
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == LAST) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_d = IDLE;
          else               drain_d = drain_q - 1'b1;
        end
        default: ;
      endcase
    end
    run_d = (state_d == RUN);
    // alert_out is launched from block HALF_SPAN-1 so it lands OUT_LAT cycles later
    al_pipe_d = {al_pipe_q[OUT_LAT-1:0], run_d && (cnt_d == HS_LAST)};
    if (resync) al_pipe_d[OUT_LAT:1] = '0;
    fd_pipe_d = {fd_pipe_q[OUT_LAT-1:0], run_d && (cnt_d == LAST)};
    qtr = 2'(cnt_q >> LOG_HS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      al_pipe_q <= '0;
      fd_pipe_q <= '0;
      mux_sel_q <= 1'b0;
      mul_en_q  <= 1'b0;
      mvs_q     <= 2'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      al_pipe_q <= al_pipe_d;
      fd_pipe_q <= fd_pipe_d;
      mux_sel_q <= run_d && cnt_d[LOG_HS];
      mul_en_q  <= mux_sel_q;
      if (state_q == RUN) mvs_q <= qtr;
      busy_q    <= run_d || (|fd_pipe_d);
      if (resync) err_q <= 1'b1;
    end
  end

  assign mux_sel     = mux_sel_q;
  assign bf_en       = mux_sel_q;
  assign mul_en      = mul_en_q;
  assign mul_val_sel = mvs_q;
  assign alert_out   = al_pipe_q[OUT_LAT];
  assign frame_done  = fd_pipe_q[OUT_LAT];
  assign busy        = busy_q;
`ifdef CU_SDF_RESYNC_EN
  assign err_resync  = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_cu_sdf_stage_seq.sv
// Bench for cu_sdf_stage_seq: event-schedule reference model, directed scenarios with literal pins, random phase.
// Builds with or without CU_SDF_RESYNC_EN.
module tb_cu_sdf_stage_seq;

  localparam int BPF = 32;
  localparam int HS  = 8;
  localparam int OL  = 2;
`ifdef CU_SDF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk, rst, alert_in;
  logic mux_sel, bf_en, mul_en, alert_out, frame_done, busy;
  logic [1:0] mul_val_sel;
`ifdef CU_SDF_RESYNC_EN
  logic err_resync;
`endif

  cu_sdf_stage_seq #(.BLK_PER_FRAME(BPF), .HALF_SPAN(HS), .OUT_LAT(OL)) dut (
    .clk(clk), .rst(rst), .alert_in(alert_in),
    .mux_sel(mux_sel), .bf_en(bf_en), .mul_en(mul_en), .mul_val_sel(mul_val_sel),
    .alert_out(alert_out), .frame_done(frame_done), .busy(busy)
`ifdef CU_SDF_RESYNC_EN
    , .err_resync(err_resync)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: block index of the current cycle plus scheduled pulse times
  int t = 0;
  int blk = -1;
  int al_q[$];
  int dn_q[$];
  int cur_al = -1, cur_dn = -1;
  int e_mux = 0, e_mul = 0, e_mvs = 0, e_al = 0, e_fd = 0, e_busy = 0, e_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, t, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic a);
    int  bp;
    bit  mid;
    bp = blk;
    t++;
    if (r) begin
      blk = -1;
      al_q.delete();
      dn_q.delete();
      cur_al = -1; cur_dn = -1;
      e_mux = 0; e_mul = 0; e_mvs = 0; e_al = 0; e_fd = 0; e_busy = 0; e_err = 0;
    end else begin
      e_mul = e_mux;
      if (bp >= 0) e_mvs = (bp / HS) % 4;
      mid = (bp >= 0) && (bp != BPF - 1);
      if (a && mid && RESYNC) begin
        for (int i = al_q.size() - 1; i >= 0; i--) if (al_q[i] == cur_al) al_q.delete(i);
        for (int i = dn_q.size() - 1; i >= 0; i--) if (dn_q[i] == cur_dn) dn_q.delete(i);
        e_err = 1;
      end
      if (a && (!mid || RESYNC)) begin
        blk = 0;
        cur_al = (t - 1) + HS + OL;
        cur_dn = (t - 1) + BPF + OL;
        al_q.push_back(cur_al);
        dn_q.push_back(cur_dn);
      end else begin
        blk = (bp >= 0 && bp < BPF - 1) ? bp + 1 : -1;
      end
      for (int i = al_q.size() - 1; i >= 0; i--) if (al_q[i] < t) al_q.delete(i);
      for (int i = dn_q.size() - 1; i >= 0; i--) if (dn_q[i] < t) dn_q.delete(i);
      e_al = 0;
      e_fd = 0;
      foreach (al_q[i]) if (al_q[i] == t) e_al = 1;
      foreach (dn_q[i]) if (dn_q[i] == t) e_fd = 1;
      e_mux  = (blk >= 0) ? (blk / HS) % 2 : 0;
      e_busy = ((blk >= 0) || (dn_q.size() > 0)) ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    chk("mux_sel", mux_sel, e_mux);
    chk("bf_en", bf_en, e_mux);
    chk("mul_en", mul_en, e_mul);
    chk("mul_val_sel", mul_val_sel, e_mvs);
    chk("alert_out", alert_out, e_al);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
`ifdef CU_SDF_RESYNC_EN
    chk("err_resync", err_resync, e_err);
`endif
  endtask

  // inputs held for one cycle, model advanced at the edge, outputs checked on the falling edge
  task automatic cycle(input logic r, input logic a);
    rst = r;
    alert_in = a;
    @(posedge clk);
    model_step(r, a);
    @(negedge clk);
    compare_all();
  endtask

  // alert at T0, then n cycles; offsets o are relative to T0 and literal pulse times are pinned
  task automatic run_seq(input int n, input int a2, input int r_at,
                         input int ea1, input int ea2, input int ed1, input int ed2,
                         input bit lit_mux);
    int o;
    cycle(1'b0, 1'b1);
    for (int i = 1; i <= n; i++) begin
      cycle(i == r_at, i == a2);
      o = i + 1;
      chk("lit_alert_out", alert_out, (o == ea1 || o == ea2) ? 1 : 0);
      chk("lit_frame_done", frame_done, (o == ed1 || o == ed2) ? 1 : 0);
      if (lit_mux) begin
        chk("lit_mux_sel", mux_sel, ((o >= 9 && o <= 16) || (o >= 25 && o <= 32)) ? 1 : 0);
        if (o == 26) chk("lit_mul_val_sel", mul_val_sel, 3);
        if (o == 34) chk("lit_busy_end", busy, 1);
        if (o == 35) chk("lit_busy_off", busy, 0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    alert_in = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
    idle(6);

    run_seq(40, -1, -1, 10, -1, 34, -1, 1'b1);
    idle(5);

    run_seq(70, 32, -1, 10, 42, 34, 66, 1'b0);
    idle(5);

    if (RESYNC) run_seq(50, 12, -1, 10, 22, -1, 46, 1'b0);
    else        run_seq(50, 12, -1, 10, -1, 34, -1, 1'b1);
    idle(5);

    run_seq(40, -1, 20, 10, -1, -1, -1, 1'b0);
    run_seq(40, -1, -1, 10, -1, 34, -1, 1'b1);
    idle(5);

    run_seq(72, 33, -1, 10, 43, 34, 67, 1'b0);
    idle(5);

    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0));
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
